tx_block_framer: RTL and testbench

TX_BLOCK_FRAMER -- requirements
Module: tx_block_framer

---
 rtl/tx_block_framer.sv | 119 +++++++++++
 tb/tb_tx_block_framer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_framer.sv
`default_nettype none
// tx_block_framer: tags 512-bit beats with 128b/130b block start and sync header behind a 2-entry FIFO.
// Optional feature: define TX_BLOCK_FRAMER_ERR_CNT_EN to add the saturating hdr_err_cnt output.
module tx_block_framer #(
  parameter int BEATS_PER_BLOCK = 4
) (
  input  logic         pclk,
  input  logic         reset,
  input  logic [511:0] in_data,
  input  logic [63:0]  in_valid,
  input  logic [63:0]  in_datak,
  input  logic         in_sync_header,
  output logic         in_ready,
  input  logic         phy_ready,
  output logic [511:0] tx_data,
  output logic [63:0]  tx_datak,
  output logic [63:0]  tx_valid,
  output logic         tx_data_valid,
  output logic         tx_start_block,
  output logic [1:0]   tx_sync_header,
  output logic         hdr_err
`ifdef TX_BLOCK_FRAMER_ERR_CNT_EN
  ,
  output logic [7:0]   hdr_err_cnt
`endif
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_BLOCK - 1);

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  datak;
    logic [63:0]  valid;
    logic         start;
    logic         os;
  } entry_t;

  entry_t     head;
  entry_t     tail;
  entry_t     incoming;
  logic [1:0] count;
  logic [1:0] beat_cnt;
  logic       blk_hdr;
  logic       err_q;
  logic       first;
  logic       accept;
  logic       pop;
  logic       nonempty;

  // Reset masks the outputs combinationally so they read 0 for the whole reset window.
  assign nonempty = (count != 2'd0) && !reset;
  assign in_ready = (count != 2'd2) && !reset;
  assign accept   = in_ready && (in_valid != '0);
  assign pop      = nonempty && phy_ready;
  assign first    = (beat_cnt == 2'd0);

  assign incoming = '{data:  in_data,
                      datak: in_datak,
                      valid: in_valid,
                      start: first,
                      os:    first ? in_sync_header : blk_hdr};

  always_ff @(posedge pclk) begin
    if (reset) begin
      count    <= 2'd0;
      beat_cnt <= 2'd0;
      blk_hdr  <= 1'b0;
      err_q    <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      err_q <= accept && !first && (in_sync_header != blk_hdr);
      if (accept) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? 2'd0 : beat_cnt + 2'd1;
        if (first) begin
          blk_hdr <= in_sync_header;
        end
      end
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) head <= incoming;
          else               tail <= incoming;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // Push and pop together can only happen with exactly one entry held.
        2'b11: head <= incoming;
        default: ;
      endcase
    end
  end

  assign tx_data_valid  = nonempty;
  assign tx_data        = nonempty ? head.data  : '0;
  assign tx_datak       = nonempty ? head.datak : '0;
  assign tx_valid       = nonempty ? head.valid : '0;
  assign tx_start_block = nonempty && head.start;
  assign tx_sync_header = nonempty ? (head.os ? 2'b01 : 2'b10) : 2'b00;
  assign hdr_err        = err_q && !reset;

`ifdef TX_BLOCK_FRAMER_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge pclk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (err_q && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign hdr_err_cnt = err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_block_framer.sv
`default_nettype none
// Randomized scoreboard bench for tx_block_framer against a block-level reference model.
module tb_tx_block_framer;
  localparam int B = 4;

  logic         pclk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] in_data = '0;
  logic [63:0]  in_valid = '0;
  logic [63:0]  in_datak = '0;
  logic         in_sync_header = 1'b0;
  logic         in_ready;
  logic         phy_ready = 1'b0;
  logic [511:0] tx_data;
  logic [63:0]  tx_datak;
  logic [63:0]  tx_valid;
  logic         tx_data_valid;
  logic         tx_start_block;
  logic [1:0]   tx_sync_header;
  logic         hdr_err;
`ifdef TX_BLOCK_FRAMER_ERR_CNT_EN
  logic [7:0]   hdr_err_cnt;
`endif

  tx_block_framer #(.BEATS_PER_BLOCK(B)) dut (
    .pclk(pclk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_datak(in_datak), .in_sync_header(in_sync_header), .in_ready(in_ready),
    .phy_ready(phy_ready), .tx_data(tx_data), .tx_datak(tx_datak), .tx_valid(tx_valid),
    .tx_data_valid(tx_data_valid), .tx_start_block(tx_start_block),
    .tx_sync_header(tx_sync_header), .hdr_err(hdr_err)
`ifdef TX_BLOCK_FRAMER_ERR_CNT_EN
    , .hdr_err_cnt(hdr_err_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  datak;
    logic [63:0]  valid;
    logic         start;
    logic [1:0]   sh;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_cnt = 0;
  int   accepted = 0;
  logic model_blk = 1'b0;
  logic exp_err = 1'b0;
  int   exp_err_cnt = 0;
  int   phy_hold = 0;
  int   phy_mode = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: occupancy, block position from accepted-beat count, expected beats into scoreboard.
  always @(negedge pclk) begin : model
    int   pos;
    int   acc;
    int   pp;
    exp_t e;
    chk("in_ready", 512'(in_ready), 512'(!reset && model_cnt < 2));
    chk("tx_data_valid", 512'(tx_data_valid), 512'(!reset && model_cnt > 0));
    chk("hdr_err", 512'(hdr_err), 512'(!reset && exp_err));
    if (reset || model_cnt == 0) begin
      chk("idle_data", tx_data, 512'(0));
      chk("idle_ctrl", 512'({tx_start_block, tx_sync_header, tx_valid, tx_datak}), 512'(0));
    end
`ifdef TX_BLOCK_FRAMER_ERR_CNT_EN
    if (!reset) chk("hdr_err_cnt", 512'(hdr_err_cnt), 512'(exp_err_cnt));
`endif
    if (reset) begin
      model_cnt   = 0;
      accepted    = 0;
      model_blk   = 1'b0;
      exp_err     = 1'b0;
      exp_err_cnt = 0;
      sbq.delete();
    end else begin
      if (exp_err && exp_err_cnt < 255) exp_err_cnt++;
      acc = (model_cnt < 2 && in_valid != '0) ? 1 : 0;
      pp  = (model_cnt > 0 && phy_ready) ? 1 : 0;
      exp_err = 1'b0;
      if (acc == 1) begin
        pos = accepted % B;
        if (pos == 0) model_blk = in_sync_header;
        else if (in_sync_header != model_blk) exp_err = 1'b1;
        e.data  = in_data;
        e.datak = in_datak;
        e.valid = in_valid;
        e.start = (pos == 0);
        e.sh    = model_blk ? 2'b01 : 2'b10;
        sbq.push_back(e);
        accepted++;
      end
      model_cnt = model_cnt + acc - pp;
    end
  end

  // Monitor: every beat the PHY takes must be the oldest expected beat.
  always @(negedge pclk) begin : monitor
    exp_t f;
    if (tx_data_valid && phy_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", tx_data);
      end else begin
        f = sbq.pop_front();
        chk("beat_data", tx_data, f.data);
        chk("beat_ctrl", 512'({tx_start_block, tx_sync_header, tx_valid, tx_datak}),
            512'({f.start, f.sh, f.valid, f.datak}));
      end
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_phy();
    if (phy_hold > 0) begin
      phy_ready = 1'b0;
      phy_hold--;
    end else begin
      phy_ready = (phy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input logic hdr, input logic [63:0] v);
    int   n;
    logic got;
    n = 0;
    in_data        = rand512();
    in_datak       = {$urandom, $urandom};
    in_valid       = v;
    in_sync_header = hdr;
    do begin
      set_phy();
      @(negedge pclk);
      got = in_ready;
      @(posedge pclk);
      #1;
      n++;
    end while (!got && n < 50);
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected acceptance", n);
    end
    in_valid = '0;
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    repeat (n) begin
      set_phy();
      @(posedge pclk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    logic        hdr;
    logic [63:0] v;
    repeat (3) @(posedge pclk);
    #1;
    reset = 1'b0;

    repeat (8) send(1'b0, '1);
    idle(3);
    repeat (4) send(1'b1, '1);
    repeat (4) send(1'b0, '1);
    idle(3);
    send(1'b0, '1); send(1'b0, '1); send(1'b1, '1); send(1'b1, '1);
    idle(3);
    phy_hold = 5;
    repeat (8) send(1'b0, '1);
    idle(3);
    send(1'b0, '1); idle(2); send(1'b0, '1); idle(1);
    send(1'b0, '1); idle(3); send(1'b0, '1); send(1'b1, '1);
    idle(3);

    phy_mode = 1;
    hdr = 1'b0;
    repeat (300) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 7) == 0) hdr = ~hdr;
        v = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
        if (v == '0) v = 64'd1;
        send(hdr, v);
      end
    end
    phy_mode = 0;
    idle(6);

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    phy_hold = 20;
    send(1'b0, '1);
    send(1'b0, '1);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    phy_hold = 0;
    repeat (4) send(1'b1, '1);
    idle(10);

    chk("drained", 512'(sbq.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
